// File: rtl/datapath_pkg.sv
// Shared width, ALU op indices and op enum for the datapath slice.
// Optional MUL/DIV hardware is enabled with the DATAPATH_MULDIV_EN macro.
package datapath_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ALU_OPS = 12;

  localparam int unsigned OP_AND  = 0;
  localparam int unsigned OP_OR   = 1;
  localparam int unsigned OP_ADD  = 2;
  localparam int unsigned OP_SUB  = 3;
  localparam int unsigned OP_MUL  = 4;
  localparam int unsigned OP_DIV  = 5;
  localparam int unsigned OP_SHR  = 6;
  localparam int unsigned OP_SHL  = 7;
  localparam int unsigned OP_ROTR = 8;
  localparam int unsigned OP_ROTL = 9;
  localparam int unsigned OP_NEG  = 10;
  localparam int unsigned OP_NOT  = 11;

  typedef enum logic [3:0] {
    ALU_AND  = 4'd0,
    ALU_OR   = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_MUL  = 4'd4,
    ALU_DIV  = 4'd5,
    ALU_SHR  = 4'd6,
    ALU_SHL  = 4'd7,
    ALU_ROTR = 4'd8,
    ALU_ROTL = 4'd9,
    ALU_NEG  = 4'd10,
    ALU_NOT  = 4'd11
  } alu_op_e;

  // One bit per op, bit index equals the op index above.
  typedef logic [ALU_OPS-1:0] alu_sel_t;

  // Lowest-indexed asserted select wins; returns ALU_AND when none is set.
  function automatic alu_op_e lowest_op(input alu_sel_t sel);
    alu_op_e op;
    op = ALU_AND;
    for (int i = int'(ALU_OPS) - 1; i >= 0; i--) begin
      if (sel[i]) op = alu_op_e'(4'(i));
    end
    return op;
  endfunction

  function automatic logic [2*DATA_W-1:0] zext(input logic [DATA_W-1:0] v);
    return {{DATA_W{1'b0}}, v};
  endfunction

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: A = Y, B = bus; produces the 64-bit value loaded into Z.
// MUL/DIV logic exists only when DATAPATH_MULDIV_EN is defined; otherwise they yield 0.
module datapath_alu
  import datapath_pkg::*;
(
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  alu_sel_t            op_sel,
  input  logic                inc_pc,
  output logic [2*DATA_W-1:0] result_c
);

  localparam int unsigned SH_W = $clog2(DATA_W);

  logic [SH_W-1:0]     shamt;
  logic [2*DATA_W-1:0] rot_l;
  logic [2*DATA_W-1:0] rot_r;
  logic [2*DATA_W-1:0] mul_res;
  logic [2*DATA_W-1:0] div_res;
  alu_op_e             op;

  assign shamt = b[SH_W-1:0];

  // Rotates via a doubled operand; an amount of 0 returns A unchanged.
  assign rot_l = {a, a} << shamt;
  assign rot_r = {a, a} >> shamt;

`ifdef DATAPATH_MULDIV_EN
  logic signed [2*DATA_W-1:0] product;
  logic signed [DATA_W-1:0]   quot;
  logic signed [DATA_W-1:0]   rem;

  assign product = $signed({{DATA_W{a[DATA_W-1]}}, a}) *
                   $signed({{DATA_W{b[DATA_W-1]}}, b});
  assign mul_res = product;

  // Divide by zero returns all-ones quotient and A as remainder; MIN/-1 wraps.
  always_comb begin
    quot = '1;
    rem  = $signed(a);
    if (b == '0) begin
      quot = '1;
      rem  = $signed(a);
    end else if (a == {1'b1, {(DATA_W-1){1'b0}}} && b == '1) begin
      quot = $signed(a);
      rem  = '0;
    end else begin
      quot = $signed(a) / $signed(b);
      rem  = $signed(a) % $signed(b);
    end
  end

  assign div_res = {rem, quot};
`else
  assign mul_res = '0;
  assign div_res = '0;
`endif

  always_comb begin
    op       = lowest_op(op_sel);
    result_c = zext(b);
    if (inc_pc) begin
      result_c = zext(b + DATA_W'(1));
    end else if (|op_sel) begin
      case (op)
        ALU_AND:  result_c = zext(a & b);
        ALU_OR:   result_c = zext(a | b);
        ALU_ADD:  result_c = zext(a + b);
        ALU_SUB:  result_c = zext(a - b);
        ALU_MUL:  result_c = mul_res;
        ALU_DIV:  result_c = div_res;
        ALU_SHR:  result_c = zext(a >> shamt);
        ALU_SHL:  result_c = zext(a << shamt);
        ALU_ROTR: result_c = zext(rot_r[DATA_W-1:0]);
        ALU_ROTL: result_c = zext(rot_l[2*DATA_W-1:DATA_W]);
        ALU_NEG:  result_c = zext(~b + DATA_W'(1));
        ALU_NOT:  result_c = zext(~b);
        default:  result_c = zext(b);
      endcase
    end
  end

endmodule

// File: rtl/datapath.sv
// Single-bus CPU datapath: register file, prioritised bus mux and the ALU feeding Z.
// Build option: DATAPATH_MULDIV_EN enables the signed multiplier and divider.
module datapath
  import datapath_pkg::*;
#(
  parameter int unsigned DATA_W = datapath_pkg::DATA_W
) (
  output logic [DATA_W-1:0] outp,
  input  logic              PCout,
  input  logic              Zhiout,
  input  logic              Zlowout,
  input  logic              MDRout,
  input  logic              R2out,
  input  logic              R4out,
  input  logic              HIout,
  input  logic              LOout,
  input  logic              MARin,
  input  logic              Zin,
  input  logic              PCin,
  input  logic              MDRin,
  input  logic              IRin,
  input  logic              Yin,
  input  logic              HIin,
  input  logic              LOin,
  input  logic              IncPC,
  input  logic              Read,
  input  logic              R5in,
  input  logic              R2in,
  input  logic              R4in,
  input  logic              Clock,
  input  logic              Clear,
  input  logic [DATA_W-1:0] Mdatain,
  input  logic              AND,
  input  logic              OR,
  input  logic              ADD,
  input  logic              SUB,
  input  logic              MUL,
  input  logic              DIV,
  input  logic              SHR,
  input  logic              SHL,
  input  logic              ROTR,
  input  logic              ROTL,
  input  logic              NEG,
  input  logic              NOT
);

  logic [DATA_W-1:0]   pc;
  logic [DATA_W-1:0]   ir;
  logic [DATA_W-1:0]   mar;
  logic [DATA_W-1:0]   mdr;
  logic [DATA_W-1:0]   y;
  logic [DATA_W-1:0]   hi;
  logic [DATA_W-1:0]   lo;
  logic [DATA_W-1:0]   r2;
  logic [DATA_W-1:0]   r4;
  logic [DATA_W-1:0]   r5;
  logic [2*DATA_W-1:0] z;
  logic [DATA_W-1:0]   bus;
  logic [2*DATA_W-1:0] alu_result;
  alu_sel_t            op_sel;
  logic                unused_regs;

  assign op_sel = {NOT, NEG, ROTL, ROTR, SHL, SHR, DIV, MUL, SUB, ADD, OR, AND};

  // Bus source mux, highest priority first; idle bus reads 0.
  always_comb begin
    bus = '0;
    if      (PCout)   bus = pc;
    else if (Zhiout)  bus = z[2*DATA_W-1:DATA_W];
    else if (Zlowout) bus = z[DATA_W-1:0];
    else if (MDRout)  bus = mdr;
    else if (R2out)   bus = r2;
    else if (R4out)   bus = r4;
    else if (HIout)   bus = hi;
    else if (LOout)   bus = lo;
  end

  assign outp = bus;

  datapath_alu u_alu (
    .a        (y),
    .b        (bus),
    .op_sel   (op_sel),
    .inc_pc   (IncPC),
    .result_c (alu_result)
  );

  // Register file; Clear wins over every load enable.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      pc  <= '0;
      ir  <= '0;
      mar <= '0;
      mdr <= '0;
      y   <= '0;
      hi  <= '0;
      lo  <= '0;
      r2  <= '0;
      r4  <= '0;
      r5  <= '0;
      z   <= '0;
    end else begin
      if (PCin)  pc  <= bus;
      if (IRin)  ir  <= bus;
      if (MARin) mar <= bus;
      if (MDRin) mdr <= Read ? Mdatain : bus;
      if (Yin)   y   <= bus;
      if (HIin)  hi  <= bus;
      if (LOin)  lo  <= bus;
      if (R2in)  r2  <= bus;
      if (R4in)  r4  <= bus;
      if (R5in)  r5  <= bus;
      if (Zin)   z   <= alu_result;
    end
  end

  // IR, MAR and R5 drive no bus source in this slice.
  assign unused_regs = ^{ir, mar, r5};

endmodule

// File: tb/tb_datapath.sv
// Directed bench for datapath with a scoreboard queue of expected values.
// Expectations for MUL/DIV follow the DATAPATH_MULDIV_EN build option.
module tb_datapath;

  logic [31:0] outp;
  logic [31:0] Mdatain;
  logic PCout, Zhiout, Zlowout, MDRout, R2out, R4out, HIout, LOout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, R5in, R2in, R4in;
  logic IncPC, Read, Clock, Clear;
  logic AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROTR, ROTL, NEG, NOT;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_checks;
  int unsigned n_passed;

  localparam int S_PC = 0, S_ZHI = 1, S_ZLO = 2, S_MDR = 3;
  localparam int S_R2 = 4, S_R4 = 5, S_HI = 6, S_LO = 7;
  localparam int D_PC = 0, D_R2 = 1, D_R4 = 2, D_Y = 3, D_HI = 4, D_LO = 5;

  localparam logic [11:0] SEL_NONE = 12'h000;
  localparam logic [11:0] SEL_AND  = 12'h001;
  localparam logic [11:0] SEL_OR   = 12'h002;
  localparam logic [11:0] SEL_ADD  = 12'h004;
  localparam logic [11:0] SEL_SUB  = 12'h008;
  localparam logic [11:0] SEL_MUL  = 12'h010;
  localparam logic [11:0] SEL_DIV  = 12'h020;
  localparam logic [11:0] SEL_SHR  = 12'h040;
  localparam logic [11:0] SEL_SHL  = 12'h080;
  localparam logic [11:0] SEL_ROTR = 12'h100;
  localparam logic [11:0] SEL_ROTL = 12'h200;
  localparam logic [11:0] SEL_NEG  = 12'h400;
  localparam logic [11:0] SEL_NOT  = 12'h800;

  datapath dut (
    .outp(outp), .PCout(PCout), .Zhiout(Zhiout), .Zlowout(Zlowout), .MDRout(MDRout),
    .R2out(R2out), .R4out(R4out), .HIout(HIout), .LOout(LOout), .MARin(MARin),
    .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .HIin(HIin),
    .LOin(LOin), .IncPC(IncPC), .Read(Read), .R5in(R5in), .R2in(R2in), .R4in(R4in),
    .Clock(Clock), .Clear(Clear), .Mdatain(Mdatain),
    .AND(AND), .OR(OR), .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV), .SHR(SHR),
    .SHL(SHL), .ROTR(ROTR), .ROTL(ROTL), .NEG(NEG), .NOT(NOT)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "timeout");
  end

  task automatic idle();
    {PCout, Zhiout, Zlowout, MDRout, R2out, R4out, HIout, LOout} = '0;
    {MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, R5in, R2in, R4in} = '0;
    {IncPC, Read} = '0;
    {NOT, NEG, ROTL, ROTR, SHL, SHR, DIV, MUL, SUB, ADD, OR, AND} = '0;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic expect_val(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic compare(input logic [63:0] obs);
    exp_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      $error("FAIL scoreboard_empty: observed %h required <entry>", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) n_passed++;
      else $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
    end
  endtask

  task automatic drive_out(input int src);
    case (src)
      S_PC:    PCout   = 1'b1;
      S_ZHI:   Zhiout  = 1'b1;
      S_ZLO:   Zlowout = 1'b1;
      S_MDR:   MDRout  = 1'b1;
      S_R2:    R2out   = 1'b1;
      S_R4:    R4out   = 1'b1;
      S_HI:    HIout   = 1'b1;
      default: LOout   = 1'b1;
    endcase
  endtask

  task automatic drive_in(input int dst);
    case (dst)
      D_PC:    PCin = 1'b1;
      D_R2:    R2in = 1'b1;
      D_R4:    R4in = 1'b1;
      D_Y:     Yin  = 1'b1;
      D_HI:    HIin = 1'b1;
      default: LOin = 1'b1;
    endcase
  endtask

  task automatic check_reg(input string tag, input int src, input logic [31:0] v);
    idle();
    drive_out(src);
    expect_val(tag, 64'(v));
    #1;
    compare(64'(outp));
    idle();
  endtask

  // Memory -> MDR -> bus -> destination register.
  task automatic load_reg(input int dst, input logic [31:0] v);
    idle();
    Read = 1'b1; MDRin = 1'b1; Mdatain = v;
    tick();
    idle();
    MDRout = 1'b1;
    drive_in(dst);
    tick();
    idle();
  endtask

  task automatic run_alu(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [11:0] sel, input logic inc,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    load_reg(D_Y, a);
    load_reg(D_R4, b);
    idle();
    R4out = 1'b1; Zin = 1'b1; IncPC = inc;
    {NOT, NEG, ROTL, ROTR, SHL, SHR, DIV, MUL, SUB, ADD, OR, AND} = sel;
    tick();
    check_reg({tag, "_lo"}, S_ZLO, exp_lo);
    check_reg({tag, "_hi"}, S_ZHI, exp_hi);
  endtask

  initial begin
    n_checks = 0;
    n_passed = 0;
    idle();
    Mdatain = '0;
    Clear = 1'b1;
    tick();
    Clear = 1'b0;

    // Reset state and idle bus.
    expect_val("bus_idle", 64'h0);
    #1;
    compare(64'(outp));
    for (int s = S_PC; s <= S_LO; s++) check_reg($sformatf("rst_src%0d", s), s, 32'h0);
    expect_val("rst_ir", 64'h0);  compare(64'(dut.ir));
    expect_val("rst_mar", 64'h0); compare(64'(dut.mar));
    expect_val("rst_y", 64'h0);   compare(64'(dut.y));
    expect_val("rst_r5", 64'h0);  compare(64'(dut.r5));

    // Clear overrides a concurrent load; bus reads the cleared source.
    load_reg(D_R2, 32'h5);
    check_reg("r2_loaded", S_R2, 32'h5);
    idle();
    R2out = 1'b1; R2in = 1'b1; Clear = 1'b1;
    tick();
    Clear = 1'b0; R2in = 1'b0;
    expect_val("clear_r2out", 64'h0);
    #1;
    compare(64'(outp));
    idle();

    // Bus priority.
    load_reg(D_R2, 32'h1111_2222);
    load_reg(D_R4, 32'h3333_4444);
    load_reg(D_HI, 32'h5555_6666);
    idle();
    R2out = 1'b1; R4out = 1'b1; HIout = 1'b1;
    expect_val("prio_r2_over_r4", 64'h1111_2222);
    #1;
    compare(64'(outp));
    idle();
    R4out = 1'b1; HIout = 1'b1;
    expect_val("prio_r4_over_hi", 64'h3333_4444);
    #1;
    compare(64'(outp));
    idle();

    // Rotate-left sequence into R5.
    load_reg(D_R2, 32'hAA22_0000);
    load_reg(D_R4, 32'h3);
    idle(); R2out = 1'b1; Yin = 1'b1; tick();
    idle(); R4out = 1'b1; ROTL = 1'b1; Zin = 1'b1; tick();
    idle(); Zlowout = 1'b1; R5in = 1'b1;
    expect_val("rotl_bus", 64'h5110_0005);
    #1;
    compare(64'(outp));
    tick();
    idle();
    expect_val("rotl_r5", 64'h5110_0005);
    compare(64'(dut.r5));

    // Instruction fetch.
    Clear = 1'b1; tick(); Clear = 1'b0;
    idle(); PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
    expect_val("fetch_pc_bus", 64'h0);
    #1;
    compare(64'(outp));
    tick();
    idle(); Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; Mdatain = 32'h1A92_0000;
    expect_val("fetch_zlo_bus", 64'h1);
    #1;
    compare(64'(outp));
    tick();
    idle(); MDRout = 1'b1; IRin = 1'b1;
    expect_val("fetch_mdr_bus", 64'h1A92_0000);
    #1;
    compare(64'(outp));
    tick();
    idle();
    expect_val("fetch_mar", 64'h0);
    compare(64'(dut.mar));
    expect_val("fetch_ir", 64'h1A92_0000);
    compare(64'(dut.ir));
    check_reg("fetch_pc", S_PC, 32'h1);

    // Same-cycle load and read: old value before the edge, new after.
    idle(); MDRout = 1'b1; Read = 1'b1; MDRin = 1'b1; Mdatain = 32'hCAFE_F00D;
    expect_val("mdr_old", 64'h1A92_0000);
    #1;
    compare(64'(outp));
    tick();
    Read = 1'b0; MDRin = 1'b0;
    expect_val("mdr_new", 64'hCAFE_F00D);
    #1;
    compare(64'(outp));
    idle();

    // ALU operations and select priority.
    run_alu("and",  32'hF0F0_1234, 32'h0FF0_FFFF, SEL_AND,  1'b0, 32'h0, 32'h00F0_1234);
    run_alu("or",   32'hF000_0000, 32'h0000_000F, SEL_OR,   1'b0, 32'h0, 32'hF000_000F);
    run_alu("add",  32'hFFFF_FFFF, 32'h2,         SEL_ADD,  1'b0, 32'h0, 32'h1);
    run_alu("sub",  32'h5,         32'h7,         SEL_SUB,  1'b0, 32'h0, 32'hFFFF_FFFE);
`ifdef DATAPATH_MULDIV_EN
    run_alu("mul",  32'hFFFF_FFFE, 32'h3,         SEL_MUL,  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_alu("div",  32'h7,         32'hFFFF_FFFE, SEL_DIV,  1'b0, 32'h1, 32'hFFFF_FFFD);
    run_alu("div0", 32'h9,         32'h0,         SEL_DIV,  1'b0, 32'h9, 32'hFFFF_FFFF);
`else
    run_alu("mul",  32'hFFFF_FFFE, 32'h3,         SEL_MUL,  1'b0, 32'h0, 32'h0);
    run_alu("div",  32'h7,         32'hFFFF_FFFE, SEL_DIV,  1'b0, 32'h0, 32'h0);
    run_alu("div0", 32'h9,         32'h0,         SEL_DIV,  1'b0, 32'h0, 32'h0);
`endif
    run_alu("shr",  32'h8000_0000, 32'h4,         SEL_SHR,  1'b0, 32'h0, 32'h0800_0000);
    run_alu("shr0", 32'h1234_5678, 32'h20,        SEL_SHR,  1'b0, 32'h0, 32'h1234_5678);
    run_alu("shl",  32'h1,         32'h1F,        SEL_SHL,  1'b0, 32'h0, 32'h8000_0000);
    run_alu("rotr", 32'h1,         32'h1,         SEL_ROTR, 1'b0, 32'h0, 32'h8000_0000);
    run_alu("rotl0", 32'hA500_0000, 32'h0,        SEL_ROTL, 1'b0, 32'h0, 32'hA500_0000);
    run_alu("neg",  32'h0,         32'h1,         SEL_NEG,  1'b0, 32'h0, 32'hFFFF_FFFF);
    run_alu("not",  32'h0,         32'h0F0F_0F0F, SEL_NOT,  1'b0, 32'h0, 32'hF0F0_F0F0);
    run_alu("nosel", 32'h7,        32'h55,        SEL_NONE, 1'b0, 32'h0, 32'h55);
    run_alu("incpc", 32'hA,        32'hFFFF_FFFF, SEL_ADD,  1'b1, 32'h0, 32'h0);
    run_alu("addsub", 32'hA,       32'h3,         SEL_ADD | SEL_SUB, 1'b0, 32'h0, 32'hD);
    run_alu("shlnot", 32'h1,       32'h4,         SEL_SHL | SEL_NOT, 1'b0, 32'h0, 32'h10);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
- REQ-001 SHALL have parameter DATA_W, default 32, giving the register and bus width; only 32 is supported.
- REQ-002 Clock  in  1  all state updates on the rising edge.
- REQ-003 Clear  in  1  reset, synchronous, active-high.
- REQ-004 outp  out  32  current internal bus value.
- REQ-005 PCout, Zhiout, Zlowout, MDRout, R2out, R4out, HIout, LOout  in  1 each  bus source selects.
- REQ-006 MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, R5in, R2in, R4in  in  1 each  register load enables.
- REQ-007 IncPC  in  1  Z receives bus+1 instead of an ALU result.
- REQ-008 Read  in  1  MDR input mux selects Mdatain (1) or bus (0).
- REQ-009 Mdatain  in  32  memory read data.
- REQ-010 AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROTR, ROTL, NEG, NOT  in  1 each  ALU operation selects.
- REQ-011 Positional port order SHALL be: outp, PCout, Zhiout, Zlowout, MDRout, R2out, R4out, HIout, LOout, MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, IncPC, Read, R5in, R2in, R4in, Clock, Clear, Mdatain, then the REQ-010 ALU selects in the order listed.

Function
- REQ-012 Registers: PC, IR, MAR, MDR, Y, HI, LO, R2, R4, R5 (32 bits each), and Z (64 bits: Zhi/Zlo).
- REQ-013 The bus is combinational, with source priority PC > Zhi > Zlo > MDR > R2 > R4 > HI > LO; it is 0 when no source select is asserted.
- REQ-014 Each register loads on a rising edge when its enable is 1 and otherwise holds; MDR loads Read ? Mdatain : bus; every other register loads the bus.
- REQ-015 ALU operands: A = Y, B = bus; Z loads the ALU result on an edge when Zin=1.
- REQ-016 Result select priority: IncPC ({0, B+1}) first, then the lowest-indexed asserted ALU select per REQ-010 order; with none asserted, Z = {0, B}.
- REQ-017 ALU results (32-bit results zero-extended into Zhi):
  - AND, OR, NOT (~B), NEG (two's complement of B).
  - ADD and SUB (A+B, A-B), mod 2^32.
  - MUL: signed 64-bit product into {Zhi, Zlo}.
  - DIV: signed; Zlo = quotient truncated toward zero, Zhi = remainder. B=0 gives Zlo=0xFFFFFFFF, Zhi=A.
  - SHR logical, SHL, ROTR, ROTL: shift amount B[4:0]; an amount of 0 returns A unchanged.
- REQ-018 Load and bus read in the same cycle: the bus reflects the old value; the new value is visible after the edge.

Reset
- REQ-019 Clear=1 at a rising edge zeroes every register, including both halves of Z; Clear overrides all load enables.
- REQ-020 While registers are cleared, outp equals the selected source, i.e. 0.

Configuration
- REQ-021 With DATAPATH_MULDIV_EN defined, MUL and DIV behave per REQ-017.
- REQ-022 Without DATAPATH_MULDIV_EN, MUL and DIV select a result of Z = 0 and no multiplier or divider logic is synthesized.

Structure
- REQ-023 Package datapath_pkg SHALL hold DATA_W, the ALU operation index constants (AND=0 … NOT=11), and the ALU op enum typedef.
- REQ-024 The ALU is sub-module datapath_alu: inputs A, B, op selects and IncPC; output a 64-bit result. The register file and bus mux stay in datapath.

Verification
- REQ-025 Rotate left: R2=0xAA220000, R4=3, Y←R2, then R4out+ROTL+Zin, then Zlowout+R5in gives R5=0x51100005, with outp showing 0x51100005 while Zlowout=1.
- REQ-026 Fetch: PC=0, PCout+MARin+IncPC+Zin, then Zlowout+PCin+Read+MDRin with Mdatain=0x1A920000, then MDRout+IRin gives MAR=0, PC=1, IR=0x1A920000.
- REQ-027 Reset: load R2=5, then Clear=1 for one edge gives all registers 0 and outp=0 with R2out=1.
- REQ-028 MUL (macro defined): Y=0xFFFFFFFE (-2), B=3 gives Zhi=0xFFFFFFFF, Zlo=0xFFFFFFFA.
- REQ-029 DIV: A=7, B=-2 gives Zlo=0xFFFFFFFD, Zhi=1; A=9, B=0 gives Zlo=0xFFFFFFFF, Zhi=9.
- REQ-030 Priority: R2out and R4out both asserted gives outp=R2; ADD and SUB both asserted gives the ADD result.
